// File: rtl/rtdf_feed_watchdog_if.sv
// Purpose: groups the watchdog's processor/controller-facing signals into one bundle.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are level or single-cycle strobes.
interface rtdf_feed_watchdog_if #(
  parameter int TRIP_WIDTH = 8
);
  // Processor-side observations and manual control
  logic                  enable;
  logic                  proc_in_packet;
  logic                  rx_fifo_rd_req;
  logic                  force_flush;
  // Recovery controls and status
  logic                  halt;
  logic                  proc_reset;
  logic                  recovering;
  logic                  tripped;
  logic [TRIP_WIDTH-1:0] trip_count;

  // Side that observes the processor and consumes recovery controls
  modport master (
    output enable,
    output proc_in_packet,
    output rx_fifo_rd_req,
    output force_flush,
    input  halt,
    input  proc_reset,
    input  recovering,
    input  tripped,
    input  trip_count
  );

  // The watchdog itself
  modport slave (
    input  enable,
    input  proc_in_packet,
    input  rx_fifo_rd_req,
    input  force_flush,
    output halt,
    output proc_reset,
    output recovering,
    output tripped,
    output trip_count
  );
endinterface

// File: rtl/rtdf_feed_watchdog.sv
// Purpose: detects a mid-packet RX-FIFO read stall and sequences halt -> processor reset -> settle -> release.
// Latency: halt rises TIMEOUT_CYCLES idle cycles after arming, or one edge after force_flush; all outputs registered.
// Backpressure: none; inputs are ignored for the whole recovery, which only reset can abort.
module rtdf_feed_watchdog #(
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int HALT_CYCLES    = 16,
  parameter int RESET_CYCLES   = 8,
  parameter int SETTLE_CYCLES  = 8,
  parameter int TRIP_WIDTH     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  rtdf_feed_watchdog_if.slave    wd
);

  // Idle timer only has to reach TIMEOUT_CYCLES-1: the trip fires on that count, so it never wraps.
  localparam int TMR_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int MAX_HR = (HALT_CYCLES > RESET_CYCLES) ? HALT_CYCLES : RESET_CYCLES;
  localparam int MAX_PH = (MAX_HR > SETTLE_CYCLES) ? MAX_HR : SETTLE_CYCLES;
  localparam int PH_W   = $clog2(MAX_PH) + 1;

  localparam logic [TMR_W-1:0] TMR_LAST    = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PH_W-1:0]  HALT_LAST   = PH_W'(HALT_CYCLES - 1);
  localparam logic [PH_W-1:0]  RESET_LAST  = PH_W'(RESET_CYCLES - 1);
  localparam logic [PH_W-1:0]  SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_WATCH  = 3'd0,
    ST_ARMED  = 3'd1,
    ST_HALT   = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_SETTLE = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [PH_W-1:0]       phase_q, phase_d;
  logic                  halt_q, halt_d;
  logic                  proc_reset_q, proc_reset_d;
  logic                  recovering_q, recovering_d;
  logic                  tripped_q, tripped_d;
  logic [TRIP_WIDTH-1:0] trip_count_q, trip_count_d;
  logic                  start_rec;
  logic                  live;

  assign live = wd.enable & wd.proc_in_packet;

  // Next-state, idle timer, phase counter and registered-output decode
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    phase_d      = phase_q;
    trip_count_d = trip_count_q;
    tripped_d    = 1'b0;
    start_rec    = 1'b0;

    case (state_q)
      ST_WATCH: begin
        timer_d = '0;
        if (wd.force_flush) begin
          start_rec = 1'b1;
        end else if (live) begin
          state_d = ST_ARMED;
        end
      end

      ST_ARMED: begin
        // Manual flush beats exit and activity; activity beats the terminal count.
        if (wd.force_flush) begin
          start_rec = 1'b1;
        end else if (!live) begin
          state_d = ST_WATCH;
          timer_d = '0;
        end else if (wd.rx_fifo_rd_req) begin
          timer_d = '0;
        end else if (timer_q == TMR_LAST) begin
          start_rec = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      ST_HALT: begin
        if (phase_q == HALT_LAST) begin
          state_d = ST_FLUSH;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end

      ST_FLUSH: begin
        if (phase_q == RESET_LAST) begin
          state_d = ST_SETTLE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end

      ST_SETTLE: begin
        if (phase_q == SETTLE_LAST) begin
          state_d = ST_WATCH;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end

      default: begin
        state_d = ST_WATCH;
        timer_d = '0;
        phase_d = '0;
      end
    endcase

    if (start_rec) begin
      state_d   = ST_HALT;
      timer_d   = '0;
      phase_d   = '0;
      tripped_d = 1'b1;
      if (trip_count_q != {TRIP_WIDTH{1'b1}}) begin
        trip_count_d = trip_count_q + TRIP_WIDTH'(1);
      end
    end

    // Outputs are decoded from the next state so they are flops aligned with the state register.
    halt_d       = (state_d == ST_HALT) || (state_d == ST_FLUSH) || (state_d == ST_SETTLE);
    recovering_d = halt_d;
    proc_reset_d = (state_d == ST_FLUSH);
  end

  // State, counters and outputs; synchronous reset returns everything to idle on the next edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_WATCH;
      timer_q      <= '0;
      phase_q      <= '0;
      halt_q       <= 1'b0;
      proc_reset_q <= 1'b0;
      recovering_q <= 1'b0;
      tripped_q    <= 1'b0;
      trip_count_q <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      phase_q      <= phase_d;
      halt_q       <= halt_d;
      proc_reset_q <= proc_reset_d;
      recovering_q <= recovering_d;
      tripped_q    <= tripped_d;
      trip_count_q <= trip_count_d;
    end
  end

  assign wd.halt       = halt_q;
  assign wd.proc_reset = proc_reset_q;
  assign wd.recovering = recovering_q;
  assign wd.tripped    = tripped_q;
  assign wd.trip_count = trip_count_q;

endmodule
